// File: rtl/s0_rs_enc.sv
// Systematic RS(N,K) encoder over GF(2^8) (poly 0x11D, t=2): message symbols pass
// straight through, followed by four parity symbols from a generator-polynomial LFSR.
//
// Handshake: a message symbol is taken on any cycle with msg_vld && msg_rdy.
// msg_rdy comes from state only and drops during the four parity cycles.
// The enc_* outputs are a registered stream with no backpressure.
module s0_rs_enc #(
  parameter int N = 255,
  parameter int K = 251
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       msg_vld,
  input  logic       msg_sop,
  input  logic [7:0] msg_data,
  output logic       msg_rdy,
  output logic       enc_vld,
  output logic       enc_sop,
  output logic       enc_eop,
  output logic       enc_par,
  output logic [7:0] enc_data,
  output logic       enc_abort,
  output logic [1:0] dbg_state
);

  generate
    if (N > 255 || N - K != 4 || K < 1) begin : g_bad_param
      $error("s0_rs_enc: N must be <= 255 and N-K must be 4");
    end
  endgenerate

  localparam logic [7:0] K_CNT = 8'(K);
  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
  localparam logic [7:0] G3 = 8'h0F;
  localparam logic [7:0] G2 = 8'h36;
  localparam logic [7:0] G1 = 8'h78;
  localparam logic [7:0] G0 = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAR  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] p3_q, p3_d, p2_q, p2_d, p1_q, p1_d, p0_q, p0_d;
  logic       enc_vld_q, enc_vld_d;
  logic       enc_sop_q, enc_sop_d;
  logic       enc_eop_q, enc_eop_d;
  logic       enc_par_q, enc_par_d;
  logic       enc_abort_q, enc_abort_d;
  logic [7:0] enc_data_q, enc_data_d;

  logic       acc;
  logic       restart;
  logic [7:0] fb;
  logic [7:0] pk2, pk1, pk0;
  logic [7:0] cnt_nxt;

  // Multiplication in GF(2^8) mod 0x11D; with a constant operand this folds to XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  assign msg_rdy   = (state_q != ST_PAR);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    p3_d        = p3_q;
    p2_d        = p2_q;
    p1_d        = p1_q;
    p0_d        = p0_q;
    enc_vld_d   = 1'b0;
    enc_sop_d   = 1'b0;
    enc_eop_d   = 1'b0;
    enc_par_d   = 1'b0;
    enc_abort_d = 1'b0;
    enc_data_d  = enc_data_q;

    acc     = msg_vld && msg_rdy;
    restart = acc && msg_sop;
    // A start-of-message symbol sees an all-zero LFSR, whatever was in flight.
    fb      = restart ? msg_data : (msg_data ^ p3_q);
    pk2     = restart ? 8'h00 : p2_q;
    pk1     = restart ? 8'h00 : p1_q;
    pk0     = restart ? 8'h00 : p0_q;
    cnt_nxt = restart ? 8'd1 : (cnt_q + 8'd1);

    case (state_q)
      ST_IDLE, ST_MSG: begin
        if (restart || (acc && state_q == ST_MSG)) begin
          p3_d        = pk2 ^ gf_mul(fb, G3);
          p2_d        = pk1 ^ gf_mul(fb, G2);
          p1_d        = pk0 ^ gf_mul(fb, G1);
          p0_d        = gf_mul(fb, G0);
          enc_vld_d   = 1'b1;
          enc_sop_d   = msg_sop;
          enc_abort_d = restart && (state_q == ST_MSG);
          enc_data_d  = msg_data;
          if (cnt_nxt == K_CNT) begin
            state_d = ST_PAR;
            cnt_d   = 8'd0;
            pcnt_d  = 8'd0;
          end else begin
            state_d = ST_MSG;
            cnt_d   = cnt_nxt;
          end
        end
      end
      ST_PAR: begin
        enc_vld_d  = 1'b1;
        enc_par_d  = 1'b1;
        enc_data_d = p3_q;
        p3_d       = p2_q;
        p2_d       = p1_q;
        p1_d       = p0_q;
        p0_d       = 8'h00;
        pcnt_d     = pcnt_q + 8'd1;
        if (pcnt_q == 8'd3) begin
          enc_eop_d = 1'b1;
          state_d   = ST_IDLE;
          pcnt_d    = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      pcnt_q      <= 8'd0;
      p3_q        <= 8'h00;
      p2_q        <= 8'h00;
      p1_q        <= 8'h00;
      p0_q        <= 8'h00;
      enc_vld_q   <= 1'b0;
      enc_sop_q   <= 1'b0;
      enc_eop_q   <= 1'b0;
      enc_par_q   <= 1'b0;
      enc_abort_q <= 1'b0;
      enc_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      p3_q        <= p3_d;
      p2_q        <= p2_d;
      p1_q        <= p1_d;
      p0_q        <= p0_d;
      enc_vld_q   <= enc_vld_d;
      enc_sop_q   <= enc_sop_d;
      enc_eop_q   <= enc_eop_d;
      enc_par_q   <= enc_par_d;
      enc_abort_q <= enc_abort_d;
      enc_data_q  <= enc_data_d;
    end
  end

  assign enc_vld   = enc_vld_q;
  assign enc_sop   = enc_sop_q;
  assign enc_eop   = enc_eop_q;
  assign enc_par   = enc_par_q;
  assign enc_abort = enc_abort_q;
  assign enc_data  = enc_data_q;

endmodule

// File: tb/tb_s0_rs_enc.sv
// Bench for s0_rs_enc: queue-based codeword model (long division by g(x)) plus
// syndrome evaluation of every emitted codeword.
module tb_s0_rs_enc;
  localparam int N = 255;
  localparam int K = 251;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       msg_vld = 1'b0;
  logic       msg_sop = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_rdy;
  logic       enc_vld, enc_sop, enc_eop, enc_par, enc_abort;
  logic [7:0] enc_data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  s0_rs_enc #(.N(N), .K(K)) dut (
    .clk(clk), .rstn(rstn),
    .msg_vld(msg_vld), .msg_sop(msg_sop), .msg_data(msg_data), .msg_rdy(msg_rdy),
    .enc_vld(enc_vld), .enc_sop(enc_sop), .enc_eop(enc_eop), .enc_par(enc_par),
    .enc_data(enc_data), .enc_abort(enc_abort), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // expected output words: {abort, sop, eop, par, data}
  logic [11:0] exp_q[$];
  logic [7:0]  cur_msg[$];
  logic [7:0]  cw_q[$];
  logic [7:0]  last_cw[$];
  int cyc = 0;
  int last_eop_cyc = -10;
  int rdy_low_cnt = 0;
  int cw_done = 0;
  int n_abort = 0;
  logic sop_follows_eop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  // Horner evaluation of the received polynomial at root.
  function automatic logic [7:0] syndrome(input logic [7:0] cw[$], input logic [7:0] root);
    logic [7:0] s;
    s = 8'h00;
    foreach (cw[i]) s = gf_mul(s, root) ^ cw[i];
    return s;
  endfunction

  // Parity = remainder of m(x)*x^4 divided by g(x), by schoolbook long division.
  task automatic push_parity();
    logic [7:0] dv[$];
    logic [7:0] g[5];
    logic [7:0] c;
    g = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    dv = cur_msg;
    repeat (4) dv.push_back(8'h00);
    for (int i = 0; i < K; i++) begin
      c = dv[i];
      for (int j = 1; j <= 4; j++) dv[i+j] = dv[i+j] ^ gf_mul(c, g[j]);
    end
    for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, 1'b0, (j == 3), 1'b1, dv[K+j]});
  endtask

  task automatic model_accept(input logic sop, input logic [7:0] d);
    if (sop) begin
      exp_q.push_back({(cur_msg.size() != 0), 1'b1, 1'b0, 1'b0, d});
      cur_msg.delete();
      cur_msg.push_back(d);
    end else if (cur_msg.size() != 0) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, d});
      cur_msg.push_back(d);
    end
    if (cur_msg.size() == K) begin
      push_parity();
      cur_msg.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      msg_vld = 1'b0;
      msg_sop = 1'b0;
    end
  endtask

  // Presents one symbol (after an optional gap) and holds it until accepted.
  task automatic send(input logic [7:0] d, input logic sop, input int gap);
    if (gap > 0) idle(gap);
    @(negedge clk);
    msg_vld  = 1'b1;
    msg_sop  = sop;
    msg_data = d;
    for (int w = 0; w < 20 && !msg_rdy; w++) @(negedge clk);
    chk("rdy_wait", {31'd0, msg_rdy}, 32'd1);
    @(posedge clk);
    model_accept(sop, d);
  endtask

  task automatic send_msg(input int len, input int mode, input int max_gap);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = (mode == 0) ? 8'h00 : (mode == 1) ? ((i == len - 1) ? 8'h01 : 8'h00)
                                            : 8'($urandom_range(0, 255));
      send(d, (i == 0), (max_gap > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, max_gap) : 0);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (!rstn) begin
      chk("rst_outs", {18'd0, enc_vld, enc_sop, enc_eop, enc_par, enc_abort, enc_data, msg_rdy}, 32'd1);
    end else begin
      if (!msg_rdy) rdy_low_cnt++;
      if (enc_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", {31'd0, enc_vld}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {20'd0, enc_abort, enc_sop, enc_eop, enc_par, enc_data}, {20'd0, e});
        end
        if (enc_abort) n_abort++;
        if (enc_sop) begin
          cw_q.delete();
          sop_follows_eop = (last_eop_cyc == cyc - 1);
        end
        cw_q.push_back(enc_data);
        if (enc_eop) begin
          last_eop_cyc = cyc;
          chk("cw_len", cw_q.size(), N);
          chk("syn0", {24'd0, syndrome(cw_q, 8'h01)}, 32'd0);
          chk("syn1", {24'd0, syndrome(cw_q, 8'h02)}, 32'd0);
          chk("syn2", {24'd0, syndrome(cw_q, 8'h04)}, 32'd0);
          chk("syn3", {24'd0, syndrome(cw_q, 8'h08)}, 32'd0);
          last_cw = cw_q;
          cw_done++;
        end
      end else begin
        chk("idle_flags", {28'd0, enc_sop, enc_eop, enc_par, enc_abort}, 32'd0);
      end
    end
  end

  initial begin
    int cw_before;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, msg_rdy}, 32'd1);
    chk("rst_data", {24'd0, enc_data}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // all-zero message: zero parity, rdy low exactly 4 cycles
    rdy_low_cnt = 0;
    send_msg(K, 0, 0);
    idle(10);
    chk("rdy_low_4", rdy_low_cnt, 4);
    chk("cw_count_1", cw_done, 1);
    for (int j = 0; j < 4; j++) chk("zero_par", {24'd0, last_cw[K+j]}, 32'd0);

    // single trailing 1: parity equals g(x) low coefficients
    send_msg(K, 1, 0);
    idle(10);
    chk("cw_count_2", cw_done, 2);
    chk("par_p3", {24'd0, last_cw[K]},   32'h0F);
    chk("par_p2", {24'd0, last_cw[K+1]}, 32'h36);
    chk("par_p1", {24'd0, last_cw[K+2]}, 32'h78);
    chk("par_p0", {24'd0, last_cw[K+3]}, 32'h40);

    // random data with random valid gaps
    send_msg(K, 2, 3);
    idle(10);
    chk("cw_count_3", cw_done, 3);

    // back-to-back codewords
    send_msg(K, 2, 0);
    send_msg(K, 2, 0);
    idle(10);
    chk("cw_count_5", cw_done, 5);
    chk("b2b_sop_after_eop", {31'd0, sop_follows_eop}, 32'd1);

    // early sop after 100 symbols, then stray non-sop symbol in IDLE
    n_abort = 0;
    send_msg(100, 2, 0);
    send_msg(K, 2, 1);
    idle(10);
    chk("abort_count", n_abort, 1);
    chk("cw_count_6", cw_done, 6);
    send(8'hA5, 1'b0, 0);
    idle(5);

    // reset in the second parity cycle
    cw_before = cw_done;
    send_msg(K, 2, 0);
    @(posedge clk);
    #1;
    rstn    = 1'b0;
    msg_vld = 1'b0;
    msg_sop = 1'b0;
    exp_q.delete();
    cur_msg.delete();
    cw_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_rdy", {31'd0, msg_rdy}, 32'd1);
    chk("post_rst_cw", cw_done, cw_before);
    send_msg(K, 2, 0);
    idle(10);
    chk("post_rst_cw_new", cw_done, cw_before + 1);

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
